// File: rtl/countdown_timer_hex_pkg.sv
//==============================================================================
// Module   : countdown_timer_hex_pkg
// Purpose  : Shared state encoding and active-low 7-segment glyphs.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package countdown_timer_hex_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

`default_nettype wire

// File: rtl/countdown_timer_hex_if.sv
//==============================================================================
// Module   : countdown_timer_hex_if
// Purpose  : Control pulses in, count/status/display out for the countdown timer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface countdown_timer_hex_if #(
   parameter int WIDTH = 8
);
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             start;
   logic [WIDTH-1:0] count;
   logic             running;
   logic             tick;
   logic             done;
   logic [6:0]       hex0;
   logic [6:0]       hex1;

   modport master (
      output load, load_value, start,
      input  count, running, tick, done, hex0, hex1
   );

   modport slave (
      input  load, load_value, start,
      output count, running, tick, done, hex0, hex1
   );
endinterface

`default_nettype wire

// File: rtl/countdown_timer_hex_hex_seg7.sv
//==============================================================================
// Module   : hex_seg7
// Purpose  : One hex digit to active-low 7-segment pattern, purely combinational.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module hex_seg7
   import countdown_timer_hex_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      case (i_nibble)
         4'h0: o_seg = SEG_0;
         4'h1: o_seg = SEG_1;
         4'h2: o_seg = SEG_2;
         4'h3: o_seg = SEG_3;
         4'h4: o_seg = SEG_4;
         4'h5: o_seg = SEG_5;
         4'h6: o_seg = SEG_6;
         4'h7: o_seg = SEG_7;
         4'h8: o_seg = SEG_8;
         4'h9: o_seg = SEG_9;
         4'hA: o_seg = SEG_A;
         4'hB: o_seg = SEG_B;
         4'hC: o_seg = SEG_C;
         4'hD: o_seg = SEG_D;
         4'hE: o_seg = SEG_E;
         4'hF: o_seg = SEG_F;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/countdown_timer_hex.sv
//==============================================================================
// Module   : countdown_timer_hex
// Purpose  : Loadable down-counter decremented at a prescaled rate, with done
//            flag and two-digit hex display.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module countdown_timer_hex
   import countdown_timer_hex_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int TICK_DIV = 50_000_000
) (
   input  logic                   clock,
   input  logic                   clear_b,
   countdown_timer_hex_if.slave   bus
);

   localparam int                 c_pre_w    = $clog2(TICK_DIV);
   localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(TICK_DIV - 1);

   state_t             r_state, w_state_nxt;
   logic [WIDTH-1:0]   r_count, w_count_nxt;
   logic [c_pre_w-1:0] r_pre,   w_pre_nxt;
   logic               r_tick,  w_tick_nxt;
   logic               r_done;
   logic               r_running;

   always_ff @(posedge clock) begin
      if (!clear_b) begin
         r_state   <= ST_IDLE;
         r_count   <= '0;
         r_pre     <= '0;
         r_tick    <= 1'b0;
         r_done    <= 1'b0;
         r_running <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_count   <= w_count_nxt;
         r_pre     <= w_pre_nxt;
         r_tick    <= w_tick_nxt;
         r_done    <= (w_state_nxt == ST_DONE);
         r_running <= (w_state_nxt == ST_RUN);
      end
   end

   // Priority: load, then start, then prescaler advance while running.
   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_pre_nxt   = r_pre;
      w_tick_nxt  = 1'b0;
      if (bus.load) begin
         w_count_nxt = bus.load_value;
         w_pre_nxt   = '0;
         w_state_nxt = ST_IDLE;
      end else if (bus.start) begin
         case (r_state)
            ST_IDLE, ST_PAUSE: if (r_count != '0) w_state_nxt = ST_RUN;
            ST_RUN:            w_state_nxt = ST_PAUSE;
            default:           w_state_nxt = r_state;
         endcase
      end else if (r_state == ST_RUN) begin
         if (r_pre == c_pre_last) begin
            w_pre_nxt   = '0;
            w_count_nxt = r_count - WIDTH'(1);
            w_tick_nxt  = 1'b1;
            if (r_count == WIDTH'(1)) w_state_nxt = ST_DONE;
         end else begin
            w_pre_nxt = r_pre + c_pre_w'(1);
         end
      end
   end

   assign bus.count   = r_count;
   assign bus.running = r_running;
   assign bus.tick    = r_tick;
   assign bus.done    = r_done;

   hex_seg7 u_hex0 (
      .i_nibble (r_count[3:0]),
      .o_seg    (bus.hex0)
   );

   hex_seg7 u_hex1 (
      .i_nibble (r_count[7:4]),
      .o_seg    (bus.hex1)
   );

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer_hex.sv
//==============================================================================
// Module   : tb_countdown_timer_hex
// Purpose  : Scoreboard bench for countdown_timer_hex with TICK_DIV=4.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_countdown_timer_hex;

   localparam logic [6:0] H0 = 7'b1000000;
   localparam logic [6:0] H2 = 7'b0100100;
   localparam logic [6:0] H3 = 7'b0110000;
   localparam logic [6:0] H5 = 7'b0010010;
   localparam logic [6:0] H8 = 7'b0000000;
   localparam logic [6:0] H9 = 7'b0010000;
   localparam logic [6:0] HE = 7'b0000110;
   localparam logic [6:0] HF = 7'b0001110;

   typedef struct {
      logic [7:0] count;
      logic       running;
      logic       done;
      logic       tick;
      logic [6:0] hex1;
      logic [6:0] hex0;
   } probe_t;

   typedef struct {
      logic [7:0] count;
      logic       done;
      int         cyc;
   } tick_t;

   logic   clock   = 1'b0;
   logic   clear_b = 1'b0;
   probe_t probe_q[$];
   string  name_q[$];
   tick_t  tick_q[$];
   probe_t p_cur;
   tick_t  t_cur;
   string  n_cur;
   int     checks     = 0;
   int     errors     = 0;
   int     cyc        = 0;
   bit     finish_req = 1'b0;
   bit     mon_done   = 1'b0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   countdown_timer_hex_if #(.WIDTH(8)) bus ();

   countdown_timer_hex #(.WIDTH(8), .TICK_DIV(4)) dut (
      .clock   (clock),
      .clear_b (clear_b),
      .bus     (bus)
   );

   // Monitor: runs just after each falling edge, once the driver has queued its expectations.
   always @(negedge clock) begin
      #2;
      while (probe_q.size() > 0) begin
         p_cur = probe_q.pop_front();
         n_cur = name_q.pop_front();
         checks++;
         if (bus.count !== p_cur.count || bus.running !== p_cur.running ||
             bus.done !== p_cur.done || bus.tick !== p_cur.tick ||
             bus.hex1 !== p_cur.hex1 || bus.hex0 !== p_cur.hex0) begin
            errors++;
            $display("FAIL %s cyc=%0d: got count=%h run=%b done=%b tick=%b hex1=%b hex0=%b, want count=%h run=%b done=%b tick=%b hex1=%b hex0=%b",
                     n_cur, cyc, bus.count, bus.running, bus.done, bus.tick, bus.hex1, bus.hex0,
                     p_cur.count, p_cur.running, p_cur.done, p_cur.tick, p_cur.hex1, p_cur.hex0);
         end
      end
      if (bus.tick === 1'b1) begin
         checks++;
         if (tick_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_tick cyc=%0d: got tick with count=%h, want no tick", cyc, bus.count);
         end else begin
            t_cur = tick_q.pop_front();
            if (bus.count !== t_cur.count || bus.done !== t_cur.done || cyc != t_cur.cyc) begin
               errors++;
               $display("FAIL tick_event: got count=%h done=%b cyc=%0d, want count=%h done=%b cyc=%0d",
                        bus.count, bus.done, cyc, t_cur.count, t_cur.done, t_cur.cyc);
            end
         end
      end
      if (finish_req && !mon_done) begin
         checks++;
         if (tick_q.size() != 0) begin
            errors++;
            $display("FAIL missing_tick: got %0d expected ticks never seen, want 0", tick_q.size());
         end
         mon_done = 1'b1;
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic expect_out(input string nm, input logic [7:0] c, input logic r,
                             input logic d, input logic t, input logic [6:0] h1,
                             input logic [6:0] h0);
      probe_t p;
      p.count = c; p.running = r; p.done = d; p.tick = t; p.hex1 = h1; p.hex0 = h0;
      probe_q.push_back(p);
      name_q.push_back(nm);
   endtask

   task automatic expect_tick(input logic [7:0] c, input logic d, input int at);
      tick_t t;
      t.count = c; t.done = d; t.cyc = at;
      tick_q.push_back(t);
   endtask

   task automatic pulse_load(input logic [7:0] v);
      bus.load_value = v;
      bus.load       = 1'b1;
      step(1);
      bus.load       = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      bus.load       = 1'b0;
      bus.start      = 1'b0;
      bus.load_value = 8'h00;

      // Reset
      step(1);
      expect_out("reset", 8'h00, 0, 0, 0, H0, H0);
      clear_b = 1'b1;

      // Count 3 down to 0
      pulse_load(8'h03);
      expect_out("load3", 8'h03, 0, 0, 0, H0, H3);
      pulse_start();
      s = cyc;
      expect_out("run3", 8'h03, 1, 0, 0, H0, H3);
      expect_tick(8'h02, 0, s + 4);
      expect_tick(8'h01, 0, s + 8);
      expect_tick(8'h00, 1, s + 12);
      step(12);
      expect_out("reach_zero", 8'h00, 0, 1, 1, H0, H0);
      step(20);
      expect_out("done_hold", 8'h00, 0, 1, 0, H0, H0);
      pulse_start();
      step(1);
      expect_out("start_in_done", 8'h00, 0, 1, 0, H0, H0);

      // Pause after one tick with the prescaler at 1, then resume
      pulse_load(8'h2A);
      pulse_start();
      s = cyc;
      expect_tick(8'h29, 0, s + 4);
      step(5);
      pulse_start();
      expect_out("pause_enter", 8'h29, 0, 0, 0, H2, H9);
      for (int i = 0; i < 10; i++) begin
         step(1);
         expect_out("pause_hold", 8'h29, 0, 0, 0, H2, H9);
      end
      pulse_start();
      s = cyc;
      expect_tick(8'h28, 0, s + 3);
      step(2);
      expect_out("resume_wait", 8'h29, 1, 0, 0, H2, H9);
      step(1);
      expect_out("resume_dec", 8'h28, 1, 0, 1, H2, H8);

      // Load and start in the same cycle while running
      pulse_load(8'h10);
      pulse_start();
      step(2);
      expect_out("run10", 8'h10, 1, 0, 0, 7'b1111001, H0);
      bus.load_value = 8'h05;
      bus.load       = 1'b1;
      bus.start      = 1'b1;
      step(1);
      bus.load       = 1'b0;
      bus.start      = 1'b0;
      expect_out("load_start_same", 8'h05, 0, 0, 0, H0, H5);
      step(8);
      expect_out("idle_hold5", 8'h05, 0, 0, 0, H0, H5);

      // Zero load then start is a no-op
      pulse_load(8'h00);
      pulse_start();
      for (int i = 0; i < 10; i++) begin
         expect_out("zero_start", 8'h00, 0, 0, 0, H0, H0);
         step(1);
      end

      // Reset mid-run, then count from FF
      pulse_load(8'h40);
      pulse_start();
      step(2);
      clear_b = 1'b0;
      step(1);
      clear_b = 1'b1;
      expect_out("reset_midrun", 8'h00, 0, 0, 0, H0, H0);
      step(5);
      expect_out("reset_idle", 8'h00, 0, 0, 0, H0, H0);
      pulse_load(8'hFF);
      expect_out("loadFF", 8'hFF, 0, 0, 0, HF, HF);
      pulse_start();
      s = cyc;
      expect_tick(8'hFE, 0, s + 4);
      step(3);
      expect_out("ff_before_dec", 8'hFF, 1, 0, 0, HF, HF);
      step(1);
      expect_out("ff_dec", 8'hFE, 1, 0, 1, HF, HE);

      step(2);
      finish_req = 1'b1;
      step(2);
      if (!mon_done) begin
         $display("FAIL monitor_stalled: got no end-of-run check, want one");
         $fatal(1, "monitor stalled");
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
